display_mode_loader: RTL and testbench

- Sequences the VGA timing generator's serial configuration interface: cfg_clk, cfg_data and en.
- On request it takes the display down, shifts a 75-bit timing word MSB-first, then re-enables it.
- The word is one of three built-in presets or a caller-supplied custom word.
- Sits between the top-level mode-select logic and the timing generator; also performs a boot-time load after reset.

---
 rtl/display_modes_pkg.sv | 78 +++++++
 rtl/cfg_serializer.sv | 82 ++++++++
 rtl/display_mode_loader.sv | 162 ++++++++++++++++
 tb/tb_display_mode_loader.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_modes_pkg.sv
// -----------------------------------------------------------------------------
// display_modes_pkg
// Shared definitions for the VGA timing-generator configuration loader:
// config word length, field bit positions, mode indices and the three
// built-in timing presets. The presets hold each timing field as its value
// minus 1 because the timing generator counts down through zero. The pulse
// count is stored exactly as listed.
// -----------------------------------------------------------------------------
package display_modes_pkg;

    localparam int CFG_LEN = 75;

    // LSB position of each field inside the 75-bit word (MSB shifted first).
    localparam int POS_PULSE_COUNT = 69;  // [74:69]
    localparam int POS_H_POL       = 68;
    localparam int POS_V_POL       = 67;
    localparam int POS_H_DISPLAY   = 56;  // [66:56]
    localparam int POS_H_FRONT     = 47;  // [55:47]
    localparam int POS_H_SYNC      = 38;  // [46:38]
    localparam int POS_H_BACK      = 29;  // [37:29]
    localparam int POS_V_DISPLAY   = 18;  // [28:18]
    localparam int POS_V_BOTTOM    = 12;  // [17:12]
    localparam int POS_V_SYNC      = 6;   // [11:6]
    localparam int POS_V_TOP       = 0;   // [5:0]

    localparam logic [1:0] MODE_640X480  = 2'd0;
    localparam logic [1:0] MODE_800X600  = 2'd1;
    localparam logic [1:0] MODE_1024X768 = 2'd2;
    localparam logic [1:0] MODE_CUSTOM   = 2'd3;

    typedef logic [CFG_LEN-1:0] cfg_word_t;

    function automatic cfg_word_t pack_timing(
        input logic [5:0]  pulse_count,
        input logic        h_pol,
        input logic        v_pol,
        input logic [10:0] h_display,
        input logic [8:0]  h_front,
        input logic [8:0]  h_sync,
        input logic [8:0]  h_back,
        input logic [10:0] v_display,
        input logic [5:0]  v_bottom,
        input logic [5:0]  v_sync,
        input logic [5:0]  v_top
    );
        cfg_word_t w;
        w = '0;
        w |= cfg_word_t'(pulse_count) << POS_PULSE_COUNT;
        w |= cfg_word_t'(h_pol)       << POS_H_POL;
        w |= cfg_word_t'(v_pol)       << POS_V_POL;
        w |= cfg_word_t'(h_display)   << POS_H_DISPLAY;
        w |= cfg_word_t'(h_front)     << POS_H_FRONT;
        w |= cfg_word_t'(h_sync)      << POS_H_SYNC;
        w |= cfg_word_t'(h_back)      << POS_H_BACK;
        w |= cfg_word_t'(v_display)   << POS_V_DISPLAY;
        w |= cfg_word_t'(v_bottom)    << POS_V_BOTTOM;
        w |= cfg_word_t'(v_sync)      << POS_V_SYNC;
        w |= cfg_word_t'(v_top)       << POS_V_TOP;
        return w;
    endfunction

    localparam cfg_word_t PRESET_640X480 = pack_timing(6'd8, 1'b1, 1'b1,
        11'd639, 9'd15, 9'd95, 9'd47, 11'd479, 6'd9, 6'd1, 6'd32);
    localparam cfg_word_t PRESET_800X600 = pack_timing(6'd8, 1'b0, 1'b0,
        11'd799, 9'd39, 9'd127, 9'd87, 11'd599, 6'd0, 6'd3, 6'd22);
    localparam cfg_word_t PRESET_1024X768 = pack_timing(6'd8, 1'b1, 1'b1,
        11'd1023, 9'd23, 9'd135, 9'd159, 11'd767, 6'd2, 6'd5, 6'd28);

    function automatic cfg_word_t mode_word(input logic [1:0] m, input cfg_word_t custom);
        case (m)
            MODE_640X480:  return PRESET_640X480;
            MODE_800X600:  return PRESET_800X600;
            MODE_1024X768: return PRESET_1024X768;
            default:       return custom;
        endcase
    endfunction

endpackage

// File: rtl/cfg_serializer.sv
// -----------------------------------------------------------------------------
// cfg_serializer
// Shift register, bit counter and phase timer for the serial config port.
// A start pulse begins a low phase with cfg_data = word MSB. Each cfg_clk
// phase lasts HALF_PERIOD clk cycles. At the end of every high phase the
// register shifts left and the next bit is presented. cfg_data therefore
// only changes when a low phase begins.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   load      - capture word into the shift register
//   word      - config word to capture
//   start     - begin shifting (first low phase starts next cycle)
//   cfg_clk   - serial clock (registered)
//   cfg_data  - serial data (registered)
//   last_bit  - high in the final cycle of the last high phase
// -----------------------------------------------------------------------------
module cfg_serializer #(
    parameter int CFG_LEN     = 75,
    parameter int HALF_PERIOD = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [CFG_LEN-1:0] word,
    input  logic               start,
    output logic               cfg_clk,
    output logic               cfg_data,
    output logic               last_bit
);

    localparam int PW = $clog2(HALF_PERIOD);
    localparam int BW = $clog2(CFG_LEN);

    logic [CFG_LEN-1:0] shreg;
    logic [PW-1:0]      phase_cnt;
    logic [BW-1:0]      bit_cnt;
    logic               active;
    logic               phase_end;

    assign phase_end = active && (phase_cnt == PW'(HALF_PERIOD - 1));
    assign last_bit  = phase_end && cfg_clk && (bit_cnt == BW'(CFG_LEN - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg     <= '0;
            phase_cnt <= '0;
            bit_cnt   <= '0;
            active    <= 1'b0;
            cfg_clk   <= 1'b0;
            cfg_data  <= 1'b0;
        end else if (load) begin
            shreg <= word;
        end else if (start) begin
            active    <= 1'b1;
            phase_cnt <= '0;
            bit_cnt   <= '0;
            cfg_clk   <= 1'b0;
            cfg_data  <= shreg[CFG_LEN-1];
        end else if (active) begin
            if (phase_end) begin
                phase_cnt <= '0;
                if (!cfg_clk) begin
                    cfg_clk <= 1'b1;
                end else begin
                    cfg_clk <= 1'b0;
                    shreg   <= shreg << 1;
                    if (last_bit) begin
                        active  <= 1'b0;
                        bit_cnt <= '0;
                    end else begin
                        bit_cnt  <= bit_cnt + 1'b1;
                        // Next bit sits one below the MSB until the shift lands.
                        cfg_data <= shreg[CFG_LEN-2];
                    end
                end
            end else begin
                phase_cnt <= phase_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/display_mode_loader.sv
// -----------------------------------------------------------------------------
// display_mode_loader
// Sequences the VGA timing generator's serial configuration. When a load
// starts, the loader drops en, waits SETTLE cycles, and then shifts the
// 75-bit word MSB-first through cfg_serializer. It waits SETTLE more cycles
// and then re-enables the generator. After reset it loads BOOT_MODE
// automatically. The SHIFT state covers the low and high cfg_clk phases,
// which the serializer times.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   req          - load request, sampled only in IDLE
//   mode_sel     - 0 640x480, 1 800x600, 2 1024x768, 3 custom
//   custom_cfg   - word used for mode 3, captured on acceptance
//   wait_frame   - when the display is enabled, defer the switch to frame_pulse
//   frame_pulse  - frame boundary from the timing generator
//   cfg_clk, cfg_data - serial config port
//   en           - timing generator enable
//   busy         - high from acceptance until done
//   done         - one-cycle pulse as en rises
//   cur_mode     - last successfully loaded mode
// -----------------------------------------------------------------------------
module display_mode_loader #(
    parameter int CFG_LEN     = 75,
    parameter int HALF_PERIOD = 4,
    parameter int SETTLE      = 8,
    parameter int BOOT_MODE   = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req,
    input  logic [1:0]         mode_sel,
    input  logic [CFG_LEN-1:0] custom_cfg,
    input  logic               wait_frame,
    input  logic               frame_pulse,
    output logic               cfg_clk,
    output logic               cfg_data,
    output logic               en,
    output logic               busy,
    output logic               done,
    output logic [1:0]         cur_mode
);

    import display_modes_pkg::*;

    localparam int SW = $clog2(SETTLE + 1);

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_IDLE,
        ST_WAIT_FRM,
        ST_STOP,
        ST_SHIFT,
        ST_POST,
        ST_ENABLE
    } state_t;

    state_t             state;
    logic [SW-1:0]      settle_cnt;
    logic [1:0]         load_mode;
    logic [1:0]         sel_mode;
    logic [CFG_LEN-1:0] sel_word;
    logic               ser_load;
    logic               ser_start;
    logic               last_bit;
    logic               settle_end;

    always_comb begin
        sel_mode   = (state == ST_BOOT) ? 2'(BOOT_MODE) : mode_sel;
        sel_word   = mode_word(sel_mode, custom_cfg);
        ser_load   = (state == ST_BOOT) || ((state == ST_IDLE) && req);
        settle_end = (settle_cnt == SW'(SETTLE - 1));
        ser_start  = (state == ST_STOP) && settle_end;
    end

    cfg_serializer #(
        .CFG_LEN    (CFG_LEN),
        .HALF_PERIOD(HALF_PERIOD)
    ) u_ser (
        .clk     (clk),
        .rst     (rst),
        .load    (ser_load),
        .word    (sel_word),
        .start   (ser_start),
        .cfg_clk (cfg_clk),
        .cfg_data(cfg_data),
        .last_bit(last_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_BOOT;
            settle_cnt <= '0;
            load_mode  <= 2'(BOOT_MODE);
            en         <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cur_mode   <= 2'(BOOT_MODE);
        end else begin
            done <= 1'b0;
            case (state)
                ST_BOOT: begin
                    busy       <= 1'b1;
                    load_mode  <= 2'(BOOT_MODE);
                    settle_cnt <= '0;
                    state      <= ST_STOP;
                end
                ST_IDLE: begin
                    busy <= 1'b0;
                    if (req) begin
                        busy       <= 1'b1;
                        load_mode  <= mode_sel;
                        settle_cnt <= '0;
                        // A frame_pulse arriving with req is not consumed here.
                        if (wait_frame && en) begin
                            state <= ST_WAIT_FRM;
                        end else begin
                            en    <= 1'b0;
                            state <= ST_STOP;
                        end
                    end
                end
                ST_WAIT_FRM: begin
                    if (frame_pulse) begin
                        en    <= 1'b0;
                        state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (settle_end) begin
                        settle_cnt <= '0;
                        state      <= ST_SHIFT;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (last_bit) begin
                        settle_cnt <= '0;
                        state      <= ST_POST;
                    end
                end
                ST_POST: begin
                    if (settle_end) begin
                        settle_cnt <= '0;
                        en         <= 1'b1;
                        done       <= 1'b1;
                        cur_mode   <= load_mode;
                        state      <= ST_ENABLE;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                ST_ENABLE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_display_mode_loader.sv
module tb_display_mode_loader;

    localparam int CFG_LEN  = 75;
    localparam int HP       = 4;
    localparam int SETTLE   = 8;
    localparam int LOAD_LAT = 1 + SETTLE + CFG_LEN * 2 * HP + SETTLE;
    localparam int BUDGET   = 3000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [1:0]  mode_sel = 2'd0;
    logic [74:0] custom_cfg = '0;
    logic        wait_frame = 1'b0;
    logic        frame_pulse = 1'b0;
    logic        cfg_clk, cfg_data, en, busy, done;
    logic [1:0]  cur_mode;

    display_mode_loader #(
        .CFG_LEN(CFG_LEN), .HALF_PERIOD(HP), .SETTLE(SETTLE), .BOOT_MODE(0)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .mode_sel(mode_sel),
        .custom_cfg(custom_cfg), .wait_frame(wait_frame),
        .frame_pulse(frame_pulse), .cfg_clk(cfg_clk), .cfg_data(cfg_data),
        .en(en), .busy(busy), .done(done), .cur_mode(cur_mode)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    // Reference model: timing fields laid out MSB-first per the word format.
    function automatic logic [74:0] build(input int pc, input int hp, input int vp,
        input int hd, input int hf, input int hs, input int hb,
        input int vd, input int vb, input int vs, input int vt);
        return {6'(pc), 1'(hp), 1'(vp), 11'(hd), 9'(hf), 9'(hs), 9'(hb),
                11'(vd), 6'(vb), 6'(vs), 6'(vt)};
    endfunction

    function automatic logic [74:0] exp_word(input logic [1:0] m, input logic [74:0] c);
        case (m)
            2'd0:    return build(8, 1, 1, 639, 15, 95, 47, 479, 9, 1, 32);
            2'd1:    return build(8, 0, 0, 799, 39, 127, 87, 599, 0, 3, 22);
            2'd2:    return build(8, 1, 1, 1023, 23, 135, 159, 767, 2, 5, 28);
            default: return c;
        endcase
    endfunction

    // Serial-port monitor: captures bits on cfg_clk rises and tracks timing.
    int          load_id = 0;
    bit          mon_en = 1'b0;
    int          seen_id = 0;
    int          cap_n = 0;
    logic [74:0] cap = '0;
    int          viol_phase = 0, viol_setup = 0, viol_hold = 0, viol_en = 0;
    logic        prev_clk = 1'b0, prev_data = 1'b0;
    int          phase_len = 0, stable = 0;

    always @(negedge clk) begin
        if (load_id != seen_id) begin
            seen_id = load_id;
            cap_n   = 0;
        end
        if (!mon_en) begin
            prev_clk  = cfg_clk;
            prev_data = cfg_data;
            phase_len = 0;
            stable    = 0;
        end else begin
            if (cfg_clk != prev_clk) begin
                if (cfg_clk) begin
                    if (cap_n > 0 && phase_len != HP) viol_phase++;
                    if (stable < HP) viol_setup++;
                    cap   = {cap[73:0], cfg_data};
                    cap_n++;
                end else if (phase_len != HP) begin
                    viol_phase++;
                end
                phase_len = 1;
            end else begin
                phase_len++;
            end
            if (cfg_data != prev_data) begin
                if (cfg_clk) viol_hold++;
                stable = 1;
            end else begin
                stable++;
            end
            if (cfg_clk && en) viol_en++;
            prev_clk  = cfg_clk;
            prev_data = cfg_data;
        end
    end

    // Called #1 after the acceptance edge; returns in the cycle where done is seen.
    task automatic wait_done(input int extra_at, output int lat, output int bc, output int eh);
        lat = 1; bc = 0; eh = 0;
        while (!done && lat < BUDGET) begin
            if (busy) bc++;
            if (en) eh++;
            if (extra_at > 0) begin
                req      = (lat == extra_at) || (lat == extra_at + 200);
                mode_sel = 2'd2;
            end
            @(posedge clk); #1;
            lat++;
        end
        if (done && busy) bc++;
    endtask

    task automatic run_load(input string tag, input logic [1:0] m, input logic [74:0] c,
                            input logic [74:0] expw);
        int lat, bc, eh;
        load_id++;
        mode_sel = m; custom_cfg = c; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0; mode_sel = ~m; custom_cfg = ~c;
        wait_done(0, lat, bc, eh);
        chk({tag, " latency"}, 96'(lat), 96'(LOAD_LAT));
        chk({tag, " busy cycles"}, 96'(bc), 96'(LOAD_LAT));
        chk({tag, " en high during load"}, 96'(eh), 96'(0));
        chk({tag, " bits"}, 96'(cap), 96'(expw));
        chk({tag, " bit count"}, 96'(cap_n), 96'(CFG_LEN));
        @(posedge clk); #1;
        chk({tag, " en after"}, 96'(en), 96'(1));
        chk({tag, " busy after"}, 96'(busy), 96'(0));
        chk({tag, " done width"}, 96'(done), 96'(0));
        chk({tag, " cur_mode"}, 96'(cur_mode), 96'(m));
    endtask

    typedef struct {
        logic [1:0]  mode;
        logic [74:0] custom;
        logic [74:0] expw;
    } vec_t;

    vec_t tbl[5];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        int lat, bc, eh, k;
        logic [95:0] rnd;
        logic [1:0]  rm;

        tbl[0] = '{2'd1, 75'h0, build(8, 0, 0, 799, 39, 127, 87, 599, 0, 3, 22)};
        tbl[1] = '{2'd2, 75'h0, build(8, 1, 1, 1023, 23, 135, 159, 767, 2, 5, 28)};
        tbl[2] = '{2'd0, 75'h1, build(8, 1, 1, 639, 15, 95, 47, 479, 9, 1, 32)};
        tbl[3] = '{2'd3, 75'h5_5555_5555_5555_5555_5, 75'h5_5555_5555_5555_5555_5};
        tbl[4] = '{2'd3, {3'b101, 72'h0F_F0A5_5A3C_C396_6901},
                         {3'b101, 72'h0F_F0A5_5A3C_C396_6901}};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst cfg_clk", 96'(cfg_clk), 96'(0));
        chk("rst cfg_data", 96'(cfg_data), 96'(0));
        chk("rst en", 96'(en), 96'(0));
        chk("rst busy", 96'(busy), 96'(0));
        chk("rst done", 96'(done), 96'(0));
        chk("rst cur_mode", 96'(cur_mode), 96'(0));

        // Boot load of BOOT_MODE; the first cycle after release is cycle 0
        load_id++;
        mon_en = 1'b1;
        rst = 1'b0;
        @(posedge clk); #1;
        wait_done(0, lat, bc, eh);
        chk("boot latency", 96'(lat), 96'(LOAD_LAT));
        chk("boot busy cycles", 96'(bc), 96'(LOAD_LAT));
        chk("boot en during load", 96'(eh), 96'(0));
        chk("boot bits", 96'(cap), 96'(exp_word(2'd0, '0)));
        chk("boot bit count", 96'(cap_n), 96'(CFG_LEN));
        chk("boot cur_mode", 96'(cur_mode), 96'(0));
        @(posedge clk); #1;
        chk("boot en", 96'(en), 96'(1));
        chk("boot busy", 96'(busy), 96'(0));

        // Table-driven loads
        for (int i = 0; i < 5; i++)
            run_load($sformatf("tbl%0d", i), tbl[i].mode, tbl[i].custom, tbl[i].expw);

        // Randomized loads against the reference model
        for (int i = 0; i < 4; i++) begin
            rm  = 2'($urandom_range(0, 3));
            rnd = {$urandom, $urandom, $urandom};
            run_load($sformatf("rnd%0d", i), rm, rnd[74:0], exp_word(rm, rnd[74:0]));
        end

        // wait_frame while enabled; frame_pulse with req must not be consumed
        load_id++;
        wait_frame = 1'b1; mode_sel = 2'd1; req = 1'b1; frame_pulse = 1'b1;
        @(posedge clk); #1;
        req = 1'b0; frame_pulse = 1'b0;
        eh = 0; bc = 0; k = 0;
        repeat (1000) begin
            if (!en) eh++;
            if (!busy) bc++;
            if (cfg_clk) k++;
            @(posedge clk); #1;
        end
        chk("wf en held", 96'(eh), 96'(0));
        chk("wf busy held", 96'(bc), 96'(0));
        chk("wf no shifting", 96'(k), 96'(0));
        frame_pulse = 1'b1;
        chk("wf en in pulse cycle", 96'(en), 96'(1));
        @(posedge clk); #1;
        frame_pulse = 1'b0;
        chk("wf en after pulse", 96'(en), 96'(0));
        k = 0;
        while (!cfg_clk && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk("wf first rise delay", 96'(k), 96'(SETTLE + HP));
        wait_done(0, lat, bc, eh);
        chk("wf done seen", 96'(done), 96'(1));
        chk("wf bits", 96'(cap), 96'(exp_word(2'd1, '0)));
        chk("wf cur_mode", 96'(cur_mode), 96'(1));
        wait_frame = 1'b0;
        @(posedge clk); #1;

        // req while busy is ignored
        load_id++;
        mode_sel = 2'd0; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        wait_done(100, lat, bc, eh);
        chk("busy-req latency", 96'(lat), 96'(LOAD_LAT));
        chk("busy-req bits", 96'(cap), 96'(exp_word(2'd0, '0)));
        chk("busy-req cur_mode", 96'(cur_mode), 96'(0));
        // req in the done cycle is ignored; held into the next cycle it is accepted
        mode_sel = 2'd1; req = 1'b1;
        @(posedge clk); #1;
        chk("done-cycle req ignored", 96'(busy), 96'(0));
        chk("single done", 96'(done), 96'(0));
        load_id++;
        @(posedge clk); #1;
        req = 1'b0; mode_sel = 2'd3;
        chk("next-cycle req accepted", 96'(busy), 96'(1));
        wait_done(0, lat, bc, eh);
        chk("post-done latency", 96'(lat), 96'(LOAD_LAT));
        chk("post-done bits", 96'(cap), 96'(exp_word(2'd1, '0)));
        @(posedge clk); #1;
        chk("post-done cur_mode", 96'(cur_mode), 96'(1));

        // Reset at bit 40 of a mode 2 load, then a clean boot reload
        load_id++;
        mode_sel = 2'd2; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        k = 0;
        while (cap_n < 40 && k < BUDGET) begin
            @(posedge clk); #1;
            k++;
        end
        chk("reached bit 40", 96'(cap_n), 96'(40));
        mon_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mid rst cfg_clk", 96'(cfg_clk), 96'(0));
        chk("mid rst cfg_data", 96'(cfg_data), 96'(0));
        chk("mid rst en", 96'(en), 96'(0));
        chk("mid rst busy", 96'(busy), 96'(0));
        chk("mid rst cur_mode", 96'(cur_mode), 96'(0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        load_id++;
        mon_en = 1'b1;
        rst = 1'b0;
        @(posedge clk); #1;
        wait_done(0, lat, bc, eh);
        chk("reload latency", 96'(lat), 96'(LOAD_LAT));
        chk("reload en during load", 96'(eh), 96'(0));
        chk("reload bits", 96'(cap), 96'(exp_word(2'd0, '0)));
        chk("reload bit count", 96'(cap_n), 96'(CFG_LEN));
        @(posedge clk); #1;
        chk("reload en", 96'(en), 96'(1));
        chk("reload cur_mode", 96'(cur_mode), 96'(0));

        // Serial timing over every monitored load
        chk("phase length errors", 96'(viol_phase), 96'(0));
        chk("data setup errors", 96'(viol_setup), 96'(0));
        chk("data change while high", 96'(viol_hold), 96'(0));
        chk("en high while shifting", 96'(viol_en), 96'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
